// File: rtl/md4_pkg.sv
// Shared constants and FSM state type for the MD4 message padder.
package md4_pkg;

   localparam int unsigned MD4_BLOCK_BYTES = 64;
   localparam int unsigned MD4_BLOCK_W     = MD4_BLOCK_BYTES * 8;
   localparam int unsigned MD4_LEN_OFFSET  = 56;
   localparam logic [7:0]  MD4_PAD_BYTE    = 8'h80;
   localparam int unsigned MD4_LEN_W       = 64;
   localparam int unsigned MD4_POS_W       = 6;

   typedef enum logic [2:0] {
      StIdle,
      StFill,
      StPad,
      StLen,
      StEmit
   } md4_pad_state_t;

endpackage

// File: rtl/md4_msg_padder_if.sv
// Byte-stream input and 512-bit block output of the MD4 padder.
interface md4_msg_padder_if;
   import md4_pkg::*;

   logic                   in_valid;
   logic                   in_ready;
   logic [7:0]             in_data;
   logic                   in_last;
   logic                   in_empty;
   logic                   blk_valid;
   logic                   blk_ready;
   logic [MD4_BLOCK_W-1:0] blk_data;
   logic                   blk_last;

   // Driver of the byte stream and consumer of blocks.
   modport master (
      output in_valid, in_data, in_last, in_empty, blk_ready,
      input  in_ready, blk_valid, blk_data, blk_last
   );

   // The padder itself.
   modport slave (
      input  in_valid, in_data, in_last, in_empty, blk_ready,
      output in_ready, blk_valid, blk_data, blk_last
   );

endinterface

// File: rtl/md4_pad_fill.sv
// Combinational block finisher: 0x80 at i_pad_pos, zeros above it, optional length in bytes 56..63.
module md4_pad_fill
   import md4_pkg::*;
(
   input  logic [MD4_BLOCK_W-1:0] i_buf,
   input  logic [MD4_POS_W:0]     i_pad_pos,
   input  logic [MD4_LEN_W-1:0]   i_len,
   input  logic                   i_ins_len,
   output logic [MD4_BLOCK_W-1:0] o_blk
);

   // i_pad_pos == MD4_BLOCK_BYTES means no pad byte (length-only block).
   always_comb begin
      o_blk = i_buf;
      for (int j = 0; j < MD4_BLOCK_BYTES; j++) begin
         if ((MD4_POS_W + 1)'(j) == i_pad_pos) begin
            o_blk[8*j +: 8] = MD4_PAD_BYTE;
         end else if ((MD4_POS_W + 1)'(j) > i_pad_pos) begin
            o_blk[8*j +: 8] = 8'h00;
         end
      end
      if (i_ins_len) begin
         o_blk[8*MD4_LEN_OFFSET +: MD4_LEN_W] = i_len;
      end
   end

endmodule

// File: rtl/md4_msg_padder.sv
// MD4 message padder: collects bytes into 64-byte blocks, appends 0x80/zeros/bit length.
module md4_msg_padder
   import md4_pkg::*;
#(
   parameter int unsigned LEN_W = MD4_LEN_W
) (
   input logic              clk,
   input logic              rst_n,
   md4_msg_padder_if.slave  bus
);

   localparam int unsigned CNT_W = LEN_W - 3;

   md4_pad_state_t         r_state, w_state_nxt;
   logic [MD4_POS_W-1:0]   r_pos, w_pos_nxt;
   logic [CNT_W-1:0]       r_byte_cnt, w_byte_cnt_nxt;
   logic [MD4_BLOCK_W-1:0] r_buf, w_buf_nxt;
   logic [MD4_BLOCK_W-1:0] r_blk_data, w_blk_data_nxt;
   logic                   r_blk_last, w_blk_last_nxt;
   logic                   r_full, w_full_nxt;
   logic                   r_len_pend, w_len_pend_nxt;
   logic                   r_pad_pend, w_pad_pend_nxt;

   logic                   w_in_ready;
   logic                   w_accept;
   logic [MD4_BLOCK_W-1:0] w_buf_wr;
   logic [MD4_BLOCK_W-1:0] w_fill;
   logic [MD4_POS_W:0]     w_fill_pos;
   logic                   w_ins_len;
   logic [LEN_W-1:0]       w_len;

   // Gated by rst_n so in_ready is low for the whole reset interval.
   assign w_in_ready    = rst_n && ((r_state == StIdle) || (r_state == StFill));
   assign w_accept      = bus.in_valid && w_in_ready;
   assign bus.in_ready  = w_in_ready;
   assign bus.blk_valid = (r_state == StEmit);
   assign bus.blk_data  = r_blk_data;
   assign bus.blk_last  = r_blk_last;
   assign w_len         = {r_byte_cnt, 3'b000};

   always_comb begin
      w_buf_wr = r_buf;
      w_buf_wr[{r_pos, 3'b000} +: 8] = bus.in_data;
   end

   assign w_fill_pos = (r_state == StLen) ? (MD4_POS_W + 1)'(MD4_BLOCK_BYTES) : {1'b0, r_pos};
   assign w_ins_len  = (r_state == StLen) || (r_pos <= MD4_POS_W'(MD4_LEN_OFFSET - 1));

   md4_pad_fill u_pad_fill (
      .i_buf     (r_buf),
      .i_pad_pos (w_fill_pos),
      .i_len     (w_len),
      .i_ins_len (w_ins_len),
      .o_blk     (w_fill)
   );

   always_comb begin
      w_state_nxt    = r_state;
      w_pos_nxt      = r_pos;
      w_byte_cnt_nxt = r_byte_cnt;
      w_buf_nxt      = r_buf;
      w_blk_data_nxt = r_blk_data;
      w_blk_last_nxt = r_blk_last;
      w_full_nxt     = r_full;
      w_len_pend_nxt = r_len_pend;
      w_pad_pend_nxt = r_pad_pend;
      unique case (r_state)
         StIdle, StFill: begin
            if (w_accept) begin
               w_buf_nxt      = w_buf_wr;
               w_pos_nxt      = r_pos + MD4_POS_W'(1);
               w_byte_cnt_nxt = r_byte_cnt + CNT_W'(1);
               if (bus.in_last) begin
                  w_full_nxt  = (r_pos == '1);
                  w_state_nxt = StPad;
               end else if (r_pos == '1) begin
                  w_blk_data_nxt = w_buf_wr;
                  w_blk_last_nxt = 1'b0;
                  w_state_nxt    = StEmit;
               end else begin
                  w_state_nxt = StFill;
               end
            end else if ((r_state == StIdle) && bus.in_empty) begin
               w_state_nxt = StPad;
            end
         end
         StPad: begin
            // A final byte at position 63 leaves a full data block to flush first.
            if (r_full) begin
               w_blk_data_nxt = r_buf;
               w_blk_last_nxt = 1'b0;
               w_full_nxt     = 1'b0;
               w_pad_pend_nxt = 1'b1;
            end else begin
               w_blk_data_nxt = w_fill;
               w_blk_last_nxt = w_ins_len;
               w_len_pend_nxt = !w_ins_len;
            end
            w_state_nxt = StEmit;
         end
         StLen: begin
            w_blk_data_nxt = w_fill;
            w_blk_last_nxt = 1'b1;
            w_len_pend_nxt = 1'b0;
            w_state_nxt    = StEmit;
         end
         StEmit: begin
            if (bus.blk_ready) begin
               w_buf_nxt = '0;
               if (r_blk_last) begin
                  w_byte_cnt_nxt = '0;
                  w_pos_nxt      = '0;
                  w_state_nxt    = StIdle;
               end else if (r_len_pend) begin
                  w_state_nxt = StLen;
               end else if (r_pad_pend) begin
                  w_pad_pend_nxt = 1'b0;
                  w_state_nxt    = StPad;
               end else begin
                  w_state_nxt = StFill;
               end
            end
         end
         default: w_state_nxt = StIdle;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state    <= StIdle;
         r_pos      <= '0;
         r_byte_cnt <= '0;
         r_buf      <= '0;
         r_blk_data <= '0;
         r_blk_last <= 1'b0;
         r_full     <= 1'b0;
         r_len_pend <= 1'b0;
         r_pad_pend <= 1'b0;
      end else begin
         r_state    <= w_state_nxt;
         r_pos      <= w_pos_nxt;
         r_byte_cnt <= w_byte_cnt_nxt;
         r_buf      <= w_buf_nxt;
         r_blk_data <= w_blk_data_nxt;
         r_blk_last <= w_blk_last_nxt;
         r_full     <= w_full_nxt;
         r_len_pend <= w_len_pend_nxt;
         r_pad_pend <= w_pad_pend_nxt;
      end
   end

endmodule

// File: tb/tb_md4_msg_padder.sv
// Directed bench for md4_msg_padder with hand-computed padded blocks.
module tb_md4_msg_padder;

   logic clk = 1'b0;
   logic rst_n;
   int   n_cmp = 0;
   int   n_err = 0;
   logic [7:0] msg_q[$];

   md4_msg_padder_if bus ();

   md4_msg_padder #(.LEN_W(64)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout want completion");
      $fatal(1, "watchdog");
   end

   task automatic fill_q(input int n, input bit ramp, input logic [7:0] val);
      msg_q.delete();
      for (int i = 0; i < n; i++) msg_q.push_back(ramp ? 8'(i) : val);
   endtask

   task automatic fill_abc();
      msg_q.delete();
      msg_q.push_back(8'h61);
      msg_q.push_back(8'h62);
      msg_q.push_back(8'h63);
   endtask

   // Runs from posedge+1 and returns at posedge+1 after the final transfer.
   task automatic send_q(input bit with_last);
      int   i = 0;
      int   guard = 0;
      logic hs;
      while (i < msg_q.size() && guard < 500) begin
         bus.in_valid = 1'b1;
         bus.in_data  = msg_q[i];
         bus.in_last  = with_last && (i == msg_q.size() - 1);
         hs = bus.in_ready;
         @(posedge clk); #1;
         if (hs) i++;
         guard++;
      end
      bus.in_valid = 1'b0;
      bus.in_last  = 1'b0;
      if (i != msg_q.size()) begin
         n_cmp++;
         n_err++;
         $display("FAIL send_timeout: got %0d bytes want %0d", i, msg_q.size());
      end
   endtask

   task automatic get_block(output logic [511:0] d, output logic l, output bit got);
      int n = 0;
      got = 1'b0;
      d   = '0;
      l   = 1'b0;
      while (bus.blk_valid !== 1'b1 && n < 200) begin
         @(posedge clk); #1;
         n++;
      end
      if (bus.blk_valid === 1'b1) begin
         got = 1'b1;
         d   = bus.blk_data;
         l   = bus.blk_last;
         @(posedge clk); #1;
      end
   endtask

   task automatic test_reset();
      #12;
      n_cmp++;
      if (bus.in_ready !== 1'b0) begin
         n_err++; $display("FAIL rst_in_ready: got %b want 0", bus.in_ready);
      end
      n_cmp++;
      if (bus.blk_valid !== 1'b0) begin
         n_err++; $display("FAIL rst_blk_valid: got %b want 0", bus.blk_valid);
      end
      n_cmp++;
      if (bus.blk_last !== 1'b0) begin
         n_err++; $display("FAIL rst_blk_last: got %b want 0", bus.blk_last);
      end
      n_cmp++;
      if (bus.blk_data !== 512'd0) begin
         n_err++; $display("FAIL rst_blk_data: got %h want 0", bus.blk_data);
      end
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;
      n_cmp++;
      if (bus.in_ready !== 1'b1) begin
         n_err++; $display("FAIL post_rst_in_ready: got %b want 1", bus.in_ready);
      end
   endtask

   task automatic check_abc(input string tag);
      logic [511:0] d, exp;
      logic         l;
      bit           got;
      exp = '0;
      exp[31:0]        = 32'h80636261;
      exp[14*32 +: 32] = 32'h00000018;
      fill_abc();
      send_q(1'b1);
      n_cmp++;
      if (bus.blk_valid !== 1'b0) begin
         n_err++; $display("FAIL %s_pad_cycle: got valid %b want 0", tag, bus.blk_valid);
      end
      @(posedge clk); #1;
      n_cmp++;
      if (bus.blk_valid !== 1'b1) begin
         n_err++; $display("FAIL %s_latency: got valid %b want 1", tag, bus.blk_valid);
      end
      get_block(d, l, got);
      n_cmp++;
      if (!got || d !== exp) begin
         n_err++; $display("FAIL %s_data: got %h want %h", tag, d, exp);
      end
      n_cmp++;
      if (l !== 1'b1) begin
         n_err++; $display("FAIL %s_last: got %b want 1", tag, l);
      end
      n_cmp++;
      if (bus.in_ready !== 1'b1) begin
         n_err++; $display("FAIL %s_idle_ready: got %b want 1", tag, bus.in_ready);
      end
   endtask

   task automatic test_abc();
      check_abc("abc");
   endtask

   task automatic test_empty();
      logic [511:0] d, exp;
      logic         l;
      bit           got;
      exp = '0;
      exp[31:0] = 32'h00000080;
      bus.in_empty = 1'b1;
      @(posedge clk); #1;
      bus.in_empty = 1'b0;
      get_block(d, l, got);
      n_cmp++;
      if (!got || d !== exp) begin
         n_err++; $display("FAIL empty_data: got %h want %h", d, exp);
      end
      n_cmp++;
      if (l !== 1'b1) begin
         n_err++; $display("FAIL empty_last: got %b want 1", l);
      end
   endtask

   task automatic test_55();
      logic [511:0] d, exp;
      logic         l;
      bit           got;
      exp = '0;
      for (int i = 0; i < 55; i++) exp[8*i +: 8] = 8'h41;
      exp[8*55 +: 8]   = 8'h80;
      exp[14*32 +: 32] = 32'h000001B8;
      fill_q(55, 1'b0, 8'h41);
      send_q(1'b1);
      get_block(d, l, got);
      n_cmp++;
      if (!got || d !== exp) begin
         n_err++; $display("FAIL len55_data: got %h want %h", d, exp);
      end
      n_cmp++;
      if (l !== 1'b1) begin
         n_err++; $display("FAIL len55_last: got %b want 1", l);
      end
   endtask

   task automatic test_56();
      logic [511:0] d, exp;
      logic         l;
      bit           got;
      exp = '0;
      for (int i = 0; i < 56; i++) exp[8*i +: 8] = 8'h41;
      exp[8*56 +: 8] = 8'h80;
      fill_q(56, 1'b0, 8'h41);
      send_q(1'b1);
      get_block(d, l, got);
      n_cmp++;
      if (!got || d !== exp) begin
         n_err++; $display("FAIL len56_blk0: got %h want %h", d, exp);
      end
      n_cmp++;
      if (l !== 1'b0) begin
         n_err++; $display("FAIL len56_last0: got %b want 0", l);
      end
      n_cmp++;
      if (bus.blk_valid !== 1'b0) begin
         n_err++; $display("FAIL len56_len_cycle: got valid %b want 0", bus.blk_valid);
      end
      exp = '0;
      exp[14*32 +: 32] = 32'h000001C0;
      get_block(d, l, got);
      n_cmp++;
      if (!got || d !== exp) begin
         n_err++; $display("FAIL len56_blk1: got %h want %h", d, exp);
      end
      n_cmp++;
      if (l !== 1'b1) begin
         n_err++; $display("FAIL len56_last1: got %b want 1", l);
      end
   endtask

   task automatic test_64();
      logic [511:0] d, exp;
      logic         l;
      bit           got;
      exp = '0;
      for (int i = 0; i < 64; i++) exp[8*i +: 8] = 8'(i);
      fill_q(64, 1'b1, 8'h00);
      send_q(1'b1);
      get_block(d, l, got);
      n_cmp++;
      if (!got || d !== exp || d[31:0] !== 32'h03020100) begin
         n_err++; $display("FAIL len64_blk0: got %h want %h", d, exp);
      end
      n_cmp++;
      if (l !== 1'b0) begin
         n_err++; $display("FAIL len64_last0: got %b want 0", l);
      end
      exp = '0;
      exp[31:0]        = 32'h00000080;
      exp[14*32 +: 32] = 32'h00000200;
      get_block(d, l, got);
      n_cmp++;
      if (!got || d !== exp) begin
         n_err++; $display("FAIL len64_blk1: got %h want %h", d, exp);
      end
      n_cmp++;
      if (l !== 1'b1) begin
         n_err++; $display("FAIL len64_last1: got %b want 1", l);
      end
   endtask

   task automatic test_backpressure();
      logic [511:0] d0, exp;
      int           n = 0;
      exp = '0;
      exp[31:0]        = 32'h80636261;
      exp[14*32 +: 32] = 32'h00000018;
      bus.blk_ready = 1'b0;
      fill_abc();
      send_q(1'b1);
      while (bus.blk_valid !== 1'b1 && n < 50) begin
         @(posedge clk); #1;
         n++;
      end
      d0 = bus.blk_data;
      n_cmp++;
      if (bus.blk_valid !== 1'b1 || d0 !== exp) begin
         n_err++; $display("FAIL bp_data: got %h want %h", d0, exp);
      end
      for (int c = 0; c < 5; c++) begin
         @(posedge clk); #1;
         n_cmp++;
         if (bus.blk_data !== d0 || bus.in_ready !== 1'b0 || bus.blk_valid !== 1'b1) begin
            n_err++;
            $display("FAIL bp_hold%0d: got valid %b ready %b data %h want valid 1 ready 0 data %h",
                     c, bus.blk_valid, bus.in_ready, bus.blk_data, d0);
         end
      end
      bus.blk_ready = 1'b1;
      @(posedge clk); #1;
      n_cmp++;
      if (bus.blk_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
         n_err++;
         $display("FAIL bp_release: got valid %b ready %b want valid 0 ready 1",
                  bus.blk_valid, bus.in_ready);
      end
   endtask

   task automatic test_reset_mid();
      int n = 0;
      fill_q(10, 1'b0, 8'h5A);
      send_q(1'b0);
      rst_n = 1'b0;
      #1;
      n_cmp++;
      if (bus.in_ready !== 1'b0 || bus.blk_valid !== 1'b0 || bus.blk_last !== 1'b0 ||
          bus.blk_data !== 512'd0) begin
         n_err++;
         $display("FAIL rst_fill: got ready %b valid %b last %b data %h want all 0",
                  bus.in_ready, bus.blk_valid, bus.blk_last, bus.blk_data);
      end
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;
      bus.blk_ready = 1'b0;
      fill_abc();
      send_q(1'b1);
      while (bus.blk_valid !== 1'b1 && n < 50) begin
         @(posedge clk); #1;
         n++;
      end
      rst_n = 1'b0;
      #1;
      n_cmp++;
      if (bus.blk_valid !== 1'b0 || bus.blk_data !== 512'd0) begin
         n_err++;
         $display("FAIL rst_emit: got valid %b data %h want valid 0 data 0",
                  bus.blk_valid, bus.blk_data);
      end
      bus.blk_ready = 1'b1;
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;
      check_abc("abc_after_rst");
   endtask

   initial begin
      rst_n         = 1'b0;
      bus.in_valid  = 1'b0;
      bus.in_data   = 8'h00;
      bus.in_last   = 1'b0;
      bus.in_empty  = 1'b0;
      bus.blk_ready = 1'b1;
      test_reset();
      test_abc();
      test_empty();
      test_55();
      test_56();
      test_64();
      test_backpressure();
      test_reset_mid();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
